mem_copy_dma: RTL and testbench
===============================

# mem_copy_dma

Single-channel memory initiator that drives the word-addressed req/we/addr/wdata/wmask memory port and consumes its rdata/rvalid return. It copies a block of words from a source to a destination word address, or fills a destination block with a constant pattern. It sits between a control source (testbench, boot logic or CSR block) and a single-port RAM, and is the master end of the RAM's request/response interface.

## Interface
- AW, 32, address width; addresses are word indices.
- DW, 32, data width; a multiple of 8.
- LW, 16, width of the length field in words.

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  single-cycle command strobe; sampled only in IDLE
- mode_i  in  1  0 = copy, 1 = fill; sampled with start_i
- src_i  in  AW  source word address (copy only)
- dst_i  in  AW  destination word address
- len_i  in  LW  number of words to transfer
- pattern_i  in  DW  fill value (fill only)
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle pulse at completion
- err_o  out  1  sticky; set on missing read response, cleared by the next accepted start_i
- req  out  1  memory request
- we  out  1  memory write enable
- addr  out  AW  memory word address
- wdata  out  DW  write data
- wmask  out  DW/8  byte enables; all ones on writes, zero otherwise
- rdata  in  DW  read data
- rvalid  in  1  read data valid

## Operation
- FSM states: IDLE, RD, WAIT, WR, DONE.
- IDLE, start_i=1:
  - Latches mode_i, src_i, dst_i, len_i and pattern_i.
  - Clears the word counter and err_o.
  - len_i=0 goes to DONE. Otherwise copy goes to RD and fill goes to WR.
- RD: drives req=1, we=0, addr=src+cnt. Always goes to WAIT.
- WAIT: req=0.
  - rvalid=1: captures rdata into the data register and goes to WR.
  - rvalid=0: sets err_o and goes to DONE, aborting the command.
- WR: drives req=1, we=1, wmask all ones, addr=dst+cnt.
  - wdata is the captured word in copy mode and pattern in fill mode.
  - Increments cnt.
  - If cnt+1 equals len, goes to DONE.
  - Otherwise copy goes to RD and fill stays in WR.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE.
- start_i outside IDLE is ignored and has no side effect.
- All memory-side outputs are registered. In IDLE and DONE: req=0, we=0, wmask=0. addr and wdata hold their last values.
- Address arithmetic is modulo 2^AW: src+cnt and dst+cnt wrap silently. cnt is LW bits wide.
- Overlapping source and destination are processed in ascending order with no hazard handling. A forward overlap replicates the data, and that behaviour is intended.

## Timing
- Reset values: busy_o=0, done_o=0, err_o=0, req=0, we=0, addr=0, wdata=0, wmask=0, state IDLE.
- Assertion of rst_i mid-transfer aborts immediately and asynchronously. No done_o pulse is produced, and any in-flight write is not guaranteed.
- The responder returns rvalid exactly one cycle after the read request edge, so WAIT samples rvalid in the cycle after RD.
- Copy throughput is 3 cycles per word (RD, WAIT, WR). Fill throughput is 1 cycle per word (back-to-back WR).
- Command latency, counted from the start_i edge to the done_o cycle:
  - copy: 3·len+1 cycles
  - fill: len+1 cycles
  - len=0: 1 cycle
- busy_o rises in the cycle after start_i and falls in the cycle after done_o.
- A new start_i is accepted in the first IDLE cycle after DONE.

## Structure
- Package mem_copy_dma_pkg holds:
  - the FSM state enum
  - the mode typedef (MODE_COPY=0, MODE_FILL=1)
- One flat module. The address/counter datapath is small enough that no sub-module is warranted.

## Test plan
- Copy: preload RAM[0x10..0x13]=A0..A3, start with src=0x10, dst=0x40, len=4 -> RAM[0x40..0x43]=A0..A3, done_o 13 cycles after start_i, err_o=0.
- Fill: start with mode=1, dst=0x80, len=8, pattern=0xDEADBEEF -> eight consecutive write cycles, RAM[0x80..0x87]=0xDEADBEEF, done_o 9 cycles after start_i.
- len=0 -> no req cycle at all, done_o on the next cycle, busy_o high for one cycle.
- Wrap: AW=32, dst=0xFFFFFFFE, fill len=4 -> writes hit 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Fault: responder forced to hold rvalid=0 -> err_o=1 after the first RD, no write issued, done_o pulses. The next start_i clears err_o.
- Reset and strobes:
  - rst_i asserted mid-copy -> req, busy_o and all other outputs go to 0 immediately. No done_o pulse.
  - A second start_i while busy -> ignored, and the first command completes unchanged.

Source files
------------

// File: rtl/mem_copy_dma_pkg.sv
// mem_copy_dma_pkg
// Shared types for the mem_copy_dma block.
//   state_t : FSM states of the copy/fill engine
//   mode_t  : command mode; copy moves words from src to dst, fill writes a constant pattern
package mem_copy_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } state_t;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_t;

endpackage

// File: rtl/mem_copy_dma.sv
// mem_copy_dma
// Single-channel memory initiator. Copies len words from src to dst, or fills
// len words at dst with a constant pattern, over a word-addressed
// req/we/addr/wdata/wmask port with a one-cycle rdata/rvalid read return.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i           command strobe, sampled only while idle
//   mode_i            0 = copy, 1 = fill (sampled with start_i)
//   src_i, dst_i      source / destination word addresses
//   len_i             transfer length in words
//   pattern_i         fill value
//   busy_o            command in progress
//   done_o            one-cycle completion pulse
//   err_o             sticky missing-read-response flag, cleared by the next start
//   req, we, addr, wdata, wmask   registered memory request port
//   rdata, rvalid     memory read return
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            mode_i,
    input  logic [AW-1:0]   src_i,
    input  logic [AW-1:0]   dst_i,
    input  logic [LW-1:0]   len_i,
    input  logic [DW-1:0]   pattern_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic            req,
    output logic            we,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   wdata,
    output logic [DW/8-1:0] wmask,
    input  logic [DW-1:0]   rdata,
    input  logic            rvalid
);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [AW-1:0]     src_q, src_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic [LW-1:0]     len_q, len_d;
    logic [DW-1:0]     pattern_q, pattern_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wmask_q, wmask_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_COPY;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            pattern_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d    = mode_t'(mode_i);
                    src_d     = src_i;
                    dst_d     = dst_i;
                    len_d     = len_i;
                    pattern_d = pattern_i;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    if (len_i == '0) begin
                        state_d = ST_DONE;
                    end else if (mode_t'(mode_i) == MODE_FILL) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The responder answers exactly one cycle after the read, so a
                // missing rvalid here means the read is lost: abort the command.
                if (rvalid) begin
                    state_d = ST_WR;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == len_q) begin
                    state_d = ST_DONE;
                end else if (mode_q == MODE_COPY) begin
                    state_d = ST_RD;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side outputs are registered, so they are derived from the state
    // being entered and the counter/command values that will hold there.
    // addr and wdata keep their last value outside RD/WR.
    always_comb begin
        req_d   = (state_d == ST_RD) || (state_d == ST_WR);
        we_d    = (state_d == ST_WR);
        wmask_d = (state_d == ST_WR) ? '1 : '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_d == ST_RD) begin
            addr_d = src_d + AW'(cnt_d);
        end else if (state_d == ST_WR) begin
            addr_d = dst_d + AW'(cnt_d);
            // In copy mode WR is only entered from WAIT, where rdata is valid,
            // so the write data register doubles as the captured read word.
            wdata_d = (mode_d == MODE_FILL) ? pattern_d : rdata;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign err_o  = err_q;
    assign req    = req_q;
    assign we     = we_q;
    assign addr   = addr_q;
    assign wdata  = wdata_q;
    assign wmask  = wmask_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma
// Bench for mem_copy_dma: a RAM/responder model answering reads one cycle
// after the request, a scoreboard of expected writes filled when a command
// is issued and drained by a write monitor, and directed command scenarios.
module tb_mem_copy_dma;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic            clk_i;
    logic            rst_i;
    logic            start_i;
    logic            mode_i;
    logic [AW-1:0]   src_i;
    logic [AW-1:0]   dst_i;
    logic [LW-1:0]   len_i;
    logic [DW-1:0]   pattern_i;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
    logic [DW-1:0]   rdata;
    logic            rvalid;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    wr_exp_t       sbQ[$];
    wr_exp_t       monExp;
    logic [DW-1:0] mem [logic [AW-1:0]];
    bit            faultMode;
    int            numChecks;
    int            numBad;
    int            reqCycles;
    int            busyCycles;
    int            doneCount;
    int            wrCycles;

    mem_copy_dma #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .mode_i    (mode_i),
        .src_i     (src_i),
        .dst_i     (dst_i),
        .len_i     (len_i),
        .pattern_i (pattern_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .wmask     (wmask),
        .rdata     (rdata),
        .rvalid    (rvalid)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] readMem(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numBad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Responder: read data returned exactly one cycle after the request edge,
    // suppressed entirely while faultMode is set.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= 1'b0;
            if (req && !we && !faultMode) begin
                rvalid <= 1'b1;
                rdata  <= readMem(addr);
            end
        end
    end

    // RAM write port with byte enables.
    always @(posedge clk_i) begin
        if (!rst_i && req && we) begin
            logic [DW-1:0] word;
            word = readMem(addr);
            for (int b = 0; b < DW/8; b++) begin
                if (wmask[b]) word[8*b +: 8] = wdata[8*b +: 8];
            end
            mem[addr] = word;
        end
    end

    // Monitor: sampled on the falling edge, pops the scoreboard on every write.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (busy_o) busyCycles++;
            if (done_o) doneCount++;
            if (req) begin
                reqCycles++;
                if (we) begin
                    wrCycles++;
                    checkOutput("wmask_wr", 64'(wmask), 64'(4'hF));
                    if (sbQ.size() == 0) begin
                        checkOutput("sb_unexpected_wr", 64'(sbQ.size()), 64'(1));
                    end else begin
                        monExp = sbQ.pop_front();
                        checkOutput("wr_addr", 64'(addr), 64'(monExp.addr));
                        checkOutput("wr_data", 64'(wdata), 64'(monExp.data));
                    end
                end else begin
                    checkOutput("wmask_rd", 64'(wmask), 64'(0));
                end
            end
        end
    end

    // Queue the writes this command should produce, then raise start_i for
    // the next rising edge.
    task automatic applyStimulus(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                 input logic [LW-1:0] n, input logic [DW-1:0] p, input bit pushExp);
        if (pushExp) begin
            for (int i = 0; i < int'(n); i++) begin
                wr_exp_t e;
                e.addr = d + AW'(i);
                e.data = m ? p : readMem(s + AW'(i));
                sbQ.push_back(e);
            end
        end
        @(negedge clk_i);
        mode_i    = m;
        src_i     = s;
        dst_i     = d;
        len_i     = n;
        pattern_i = p;
        start_i   = 1'b1;
    endtask

    // Count rising edges from the start_i sampling edge until done_o shows,
    // then step into the following idle cycle. -1 means the budget ran out.
    task automatic waitDone(input int startCount, input int budget, output int cycles);
        int  c;
        bit  seen;
        c    = startCount;
        seen = 1'b0;
        while (!seen && c < budget) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            c++;
            if (done_o) seen = 1'b1;
        end
        cycles = seen ? c : -1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int r0;
        int b0;
        int w0;
        int d0;

        rst_i      = 1'b1;
        start_i    = 1'b0;
        mode_i     = 1'b0;
        src_i      = '0;
        dst_i      = '0;
        len_i      = '0;
        pattern_i  = '0;
        faultMode  = 1'b0;
        numChecks  = 0;
        numBad     = 0;
        reqCycles  = 0;
        busyCycles = 0;
        doneCount  = 0;
        wrCycles   = 0;
        for (int i = 0; i < 4; i++) mem[AW'(32'h10 + i)] = 32'hA000_0000 + DW'(i);
        mem[AW'(32'h90)] = 32'h0000_1234;

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_busy",  64'(busy_o), 64'(0));
        checkOutput("rst_done",  64'(done_o), 64'(0));
        checkOutput("rst_err",   64'(err_o),  64'(0));
        checkOutput("rst_req",   64'(req),    64'(0));
        checkOutput("rst_we",    64'(we),     64'(0));
        checkOutput("rst_addr",  64'(addr),   64'(0));
        checkOutput("rst_wdata", 64'(wdata),  64'(0));
        checkOutput("rst_wmask", 64'(wmask),  64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;

        // Copy 4 words 0x10 -> 0x40
        applyStimulus(1'b0, 32'h10, 32'h40, 16'd4, 32'h0, 1'b1);
        waitDone(0, 200, cyc);
        checkOutput("copy_latency", 64'(cyc), 64'(13));
        checkOutput("copy_err", 64'(err_o), 64'(0));
        for (int i = 0; i < 4; i++)
            checkOutput("copy_ram", 64'(readMem(AW'(32'h40 + i))), 64'(32'hA000_0000 + i));
        checkOutput("copy_sb_empty", 64'(sbQ.size()), 64'(0));

        // Fill 8 words at 0x80
        w0 = wrCycles;
        applyStimulus(1'b1, 32'h0, 32'h80, 16'd8, 32'hDEAD_BEEF, 1'b1);
        waitDone(0, 200, cyc);
        checkOutput("fill_latency", 64'(cyc), 64'(9));
        checkOutput("fill_wr_cycles", 64'(wrCycles - w0), 64'(8));
        for (int i = 0; i < 8; i++)
            checkOutput("fill_ram", 64'(readMem(AW'(32'h80 + i))), 64'(32'hDEAD_BEEF));

        // Zero-length command
        r0 = reqCycles;
        b0 = busyCycles;
        applyStimulus(1'b0, 32'h10, 32'h50, 16'd0, 32'h0, 1'b1);
        waitDone(0, 200, cyc);
        checkOutput("len0_latency", 64'(cyc), 64'(1));
        checkOutput("len0_req_cycles", 64'(reqCycles - r0), 64'(0));
        checkOutput("len0_busy_cycles", 64'(busyCycles - b0), 64'(1));

        // Destination address wraps past the top of the address space
        applyStimulus(1'b1, 32'h0, 32'hFFFF_FFFE, 16'd4, 32'h5A5A_1234, 1'b1);
        waitDone(0, 200, cyc);
        checkOutput("wrap_latency", 64'(cyc), 64'(5));
        checkOutput("wrap_ram_fffffffe", 64'(readMem(32'hFFFF_FFFE)), 64'(32'h5A5A_1234));
        checkOutput("wrap_ram_ffffffff", 64'(readMem(32'hFFFF_FFFF)), 64'(32'h5A5A_1234));
        checkOutput("wrap_ram_0", 64'(readMem(32'h0)), 64'(32'h5A5A_1234));
        checkOutput("wrap_ram_1", 64'(readMem(32'h1)), 64'(32'h5A5A_1234));
        checkOutput("wrap_sb_empty", 64'(sbQ.size()), 64'(0));

        // Missing read response aborts with err_o; next start clears it
        faultMode = 1'b1;
        w0 = wrCycles;
        d0 = doneCount;
        applyStimulus(1'b0, 32'h10, 32'h60, 16'd2, 32'h0, 1'b0);
        waitDone(0, 200, cyc);
        checkOutput("fault_latency", 64'(cyc), 64'(3));
        checkOutput("fault_err", 64'(err_o), 64'(1));
        checkOutput("fault_no_write", 64'(wrCycles - w0), 64'(0));
        checkOutput("fault_done_pulse", 64'(doneCount - d0), 64'(1));
        faultMode = 1'b0;
        applyStimulus(1'b1, 32'h0, 32'h70, 16'd1, 32'h1111_2222, 1'b1);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        checkOutput("fault_err_cleared", 64'(err_o), 64'(0));
        waitDone(1, 200, cyc);
        checkOutput("clear_latency", 64'(cyc), 64'(2));
        checkOutput("clear_ram", 64'(readMem(32'h70)), 64'(32'h1111_2222));

        // Second start while busy is ignored
        applyStimulus(1'b0, 32'h10, 32'hB0, 16'd2, 32'h0, 1'b1);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(negedge clk_i);
        mode_i    = 1'b1;
        dst_i     = 32'h90;
        len_i     = 16'd3;
        pattern_i = 32'hBAD0_BAD0;
        start_i   = 1'b1;
        waitDone(1, 200, cyc);
        checkOutput("busy_start_latency", 64'(cyc), 64'(7));
        checkOutput("busy_start_ram_b0", 64'(readMem(32'hB0)), 64'(32'hA000_0000));
        checkOutput("busy_start_ram_b1", 64'(readMem(32'hB1)), 64'(32'hA000_0001));
        checkOutput("busy_start_ram_90", 64'(readMem(32'h90)), 64'(32'h0000_1234));
        checkOutput("busy_start_sb_empty", 64'(sbQ.size()), 64'(0));

        // Asynchronous reset in the middle of a copy
        d0 = doneCount;
        applyStimulus(1'b0, 32'h10, 32'hC0, 16'd4, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
        end
        checkOutput("pre_rst_req", 64'(req), 64'(1));
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_req",   64'(req),    64'(0));
        checkOutput("midrst_we",    64'(we),     64'(0));
        checkOutput("midrst_busy",  64'(busy_o), 64'(0));
        checkOutput("midrst_done",  64'(done_o), 64'(0));
        checkOutput("midrst_err",   64'(err_o),  64'(0));
        checkOutput("midrst_addr",  64'(addr),   64'(0));
        checkOutput("midrst_wdata", 64'(wdata),  64'(0));
        checkOutput("midrst_wmask", 64'(wmask),  64'(0));
        sbQ.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        checkOutput("midrst_no_done", 64'(doneCount - d0), 64'(0));
        checkOutput("midrst_idle_busy", 64'(busy_o), 64'(0));

        checkOutput("final_sb_empty", 64'(sbQ.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", numChecks, numBad);
        $finish;
    end

endmodule
